// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: byte-oriented command front end for an external ALU.
// Receives command frames over a byte stream, loads the operand and
// function registers, fires the ALU for one cycle, waits (with a timeout)
// for its result and returns the result as two bytes, low byte first,
// through a simple valid/busy byte transmitter handshake.
//
// Frame formats accepted in IDLE:
//   0xCC, A, B, FUN  -- load both operands and the function, then run
//   0xDD, FUN        -- reuse the stored operands, load a new function, run
// Any other byte seen in IDLE is silently discarded.
module alu_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_Valid,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CTRL_BUSY,
    output logic                  CMD_ERR
);

    // Command opcodes recognised in IDLE.
    localparam logic [DATA_WIDTH-1:0] CMD_FULL = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUN  = DATA_WIDTH'(8'hDD);

    // Number of consecutive WAIT_VLD cycles without ALU_Valid that abort
    // the operation. The counter holds 0..TMO_CYCLES-1.
    localparam int                TMO_CYCLES = 8;
    localparam int                TMO_W      = $clog2(TMO_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TMO_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        GET_A    = 4'd1,
        GET_B    = 4'd2,
        GET_FUN  = 4'd3,
        ALU_RUN  = 4'd4,
        WAIT_VLD = 4'd5,
        SEND_LO  = 4'd6,
        WAIT_LO  = 4'd7,
        SEND_HI  = 4'd8,
        WAIT_HI  = 4'd9
    } state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic [3:0]             fun_q;
    logic                   alu_en_q;
    logic [DATA_WIDTH-1:0]  tx_data_q;
    logic                   tx_vld_q;
    logic                   busy_q;
    logic                   cmd_err_q;
    logic [OUT_WIDTH-1:0]   result_q;
    logic [TMO_W-1:0]       tmo_cnt_q;

    // Controller FSM; every output is a register updated alongside the state,
    // so each output already reflects the state being entered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            fun_q     <= '0;
            alu_en_q  <= 1'b0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            result_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            // Single-cycle strobes fall back to zero unless re-armed below.
            alu_en_q  <= 1'b0;
            cmd_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // Decoding here (not in a separate re-arm cycle) is what
                    // lets a new frame start in the very cycle IDLE is entered.
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == CMD_FULL) begin
                            state_q <= GET_A;
                            busy_q  <= 1'b1;
                        end else if (RX_P_DATA == CMD_FUN) begin
                            state_q <= GET_FUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                GET_A: begin
                    if (RX_D_VLD) begin
                        a_q     <= RX_P_DATA;
                        state_q <= GET_B;
                    end
                end

                GET_B: begin
                    if (RX_D_VLD) begin
                        b_q     <= RX_P_DATA;
                        state_q <= GET_FUN;
                    end
                end

                GET_FUN: begin
                    // Only the low nibble selects the ALU function.
                    if (RX_D_VLD) begin
                        fun_q    <= RX_P_DATA[3:0];
                        alu_en_q <= 1'b1;
                        state_q  <= ALU_RUN;
                    end
                end

                ALU_RUN: begin
                    tmo_cnt_q <= '0;
                    state_q   <= WAIT_VLD;
                end

                WAIT_VLD: begin
                    // A result arriving on the last allowed cycle still wins
                    // over the timeout.
                    if (ALU_Valid) begin
                        result_q  <= ALU_OUT;
                        tx_data_q <= ALU_OUT[DATA_WIDTH-1:0];
                        tx_vld_q  <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= SEND_LO;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        cmd_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        tmo_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end

                SEND_LO: begin
                    // The byte counts as taken on the first cycle TX_BUSY is
                    // seen high, even if it was already high on entry.
                    if (TX_BUSY) begin
                        tx_vld_q <= 1'b0;
                        state_q  <= WAIT_LO;
                    end
                end

                WAIT_LO: begin
                    if (!TX_BUSY) begin
                        tx_data_q <= result_q[OUT_WIDTH-1 -: DATA_WIDTH];
                        tx_vld_q  <= 1'b1;
                        state_q   <= SEND_HI;
                    end
                end

                SEND_HI: begin
                    if (TX_BUSY) begin
                        tx_vld_q <= 1'b0;
                        state_q  <= WAIT_HI;
                    end
                end

                WAIT_HI: begin
                    if (!TX_BUSY) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    tx_vld_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign ALU_FUN   = fun_q;
    assign ALU_EN    = alu_en_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign CTRL_BUSY = busy_q;
    assign CMD_ERR   = cmd_err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: self-checking bench for alu_cmd_ctrl. A behavioural ALU
// answers ALU_EN after a configurable latency, a behavioural byte transmitter
// drives TX_BUSY, and every accepted TX byte is compared against a queue of
// expected bytes pushed when the matching frame is sent.
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] ALU_OUT = 16'hDEAD;
    logic        ALU_Valid = 1'b0;
    logic        TX_BUSY = 1'b0;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        CTRL_BUSY;
    logic        CMD_ERR;

    alu_cmd_ctrl #(.DATA_WIDTH(8), .OUT_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .ALU_Valid(ALU_Valid), .TX_BUSY(TX_BUSY),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .CTRL_BUSY(CTRL_BUSY), .CMD_ERR(CMD_ERR)
    );

    initial forever #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // Environment configuration.
    int busy_len     = 3;
    int accept_delay = 0;
    int alu_lat      = 1;
    bit alu_never    = 1'b0;
    bit force_busy   = 1'b0;

    // Environment state and observations.
    int cyc = 0;
    int busy_cnt = 0, wait_cnt = 0, alu_cnt = 0;
    int en_count = 0, err_count = 0, vld_count = 0, acc_count = 0;
    int en_cyc = 0, err_cyc = 0, vld_run = 0, last_run = 0;
    bit err_busy = 1'b0;
    bit was_busy;
    logic [7:0] exp_b;

    typedef struct {
        bit          dd;
        logic [7:0]  a, b, fun;
        logic [7:0]  ea, eb;
        logic [3:0]  ef;
        logic [15:0] res;
        int          lat, blen, adly;
    } vec_t;

    function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {a, b};
            default: return {8'h00, a ^ b};
        endcase
    endfunction

    // ALU and transmitter models plus TX scoreboard, all on the falling edge.
    initial forever begin
        @(negedge CLK);
        cyc++;
        if (!RST) begin
            busy_cnt = 0; wait_cnt = 0; alu_cnt = 0; vld_run = 0;
            ALU_Valid = 1'b0; ALU_OUT = 16'hDEAD; TX_BUSY = force_busy;
        end else begin
            ALU_Valid = 1'b0;
            ALU_OUT   = 16'hDEAD;
            if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    ALU_Valid = 1'b1;
                    ALU_OUT   = alu_calc(A, B, ALU_FUN);
                end
            end
            if (ALU_EN) begin
                en_count++; en_cyc = cyc;
                if (!alu_never) alu_cnt = alu_lat;
            end
            if (CMD_ERR) begin
                err_count++; err_cyc = cyc; err_busy = CTRL_BUSY;
            end

            was_busy = (busy_cnt > 0);
            if (TX_D_VLD) begin vld_count++; vld_run++; end
            if (TX_D_VLD && was_busy) begin
                checks++; errors++;
                $display("FAIL tx_overlap: TX_D_VLD=1 while transmitter busy (cycle %0d)", cyc);
            end
            if (busy_cnt > 0) busy_cnt--;
            else if (TX_D_VLD) begin
                if (wait_cnt < accept_delay) wait_cnt++;
                else begin wait_cnt = 0; busy_cnt = busy_len; end
            end
            TX_BUSY = (busy_cnt > 0) || force_busy;
            if (TX_D_VLD && TX_BUSY) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte: got %02h, expected no byte", TX_P_DATA);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (TX_P_DATA !== exp_b) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h, expected %02h", TX_P_DATA, exp_b);
                    end
                end
                acc_count++; last_run = vld_run; vld_run = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; presents one byte for one cycle.
    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n;
        n = 0;
        while (CTRL_BUSY === 1'b1 && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_idle_reached"}, 32'(CTRL_BUSY), 32'd0);
        @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_A"},         32'(A),         32'd0);
        check({tag, "_B"},         32'(B),         32'd0);
        check({tag, "_ALU_FUN"},   32'(ALU_FUN),   32'd0);
        check({tag, "_ALU_EN"},    32'(ALU_EN),    32'd0);
        check({tag, "_TX_P_DATA"}, 32'(TX_P_DATA), 32'd0);
        check({tag, "_TX_D_VLD"},  32'(TX_D_VLD),  32'd0);
        check({tag, "_CTRL_BUSY"}, 32'(CTRL_BUSY), 32'd0);
        check({tag, "_CMD_ERR"},   32'(CMD_ERR),   32'd0);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int en0, err0, acc0;
        alu_lat = v.lat; busy_len = v.blen; accept_delay = v.adly;
        en0 = en_count; err0 = err_count; acc0 = acc_count;
        exp_q.push_back(v.res[7:0]);
        exp_q.push_back(v.res[15:8]);
        if (v.dd) send_byte(8'hDD);
        else begin
            send_byte(8'hCC);
            send_byte(v.a);
            send_byte(v.b);
        end
        send_byte(v.fun);
        wait_idle(300, tag);
        check({tag, "_A"},          32'(A),                32'(v.ea));
        check({tag, "_B"},          32'(B),                32'(v.eb));
        check({tag, "_ALU_FUN"},    32'(ALU_FUN),          32'(v.ef));
        check({tag, "_alu_en_cnt"}, 32'(en_count - en0),   32'd1);
        check({tag, "_cmd_err"},    32'(err_count - err0), 32'd0);
        check({tag, "_tx_bytes"},   32'(acc_count - acc0), 32'd2);
        check({tag, "_sb_empty"},   32'(exp_q.size()),     32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        int en0, err0, acc0, v0, n;
        //          dd    a      b      fun    ea     eb     ef    res       lat blen adly
        vt[0] = '{1'b0, 8'hCC, 8'h05, 8'h00, 8'h05, 8'h03, 4'h0, 16'h0008, 1, 3,  0};
        vt[0].a = 8'h05; vt[0].b = 8'h03;
        vt[1] = '{1'b1, 8'h00, 8'h00, 8'h02, 8'h05, 8'h03, 4'h2, 16'h000F, 1, 3,  0};
        vt[2] = '{1'b0, 8'hFF, 8'h01, 8'h01, 8'hFF, 8'h01, 4'h1, 16'h00FE, 2, 3,  0};
        vt[3] = '{1'b0, 8'h01, 8'h02, 8'h01, 8'h01, 8'h02, 4'h1, 16'hFFFF, 1, 2,  2};
        vt[4] = '{1'b0, 8'h10, 8'h20, 8'h02, 8'h10, 8'h20, 4'h2, 16'h0200, 8, 3,  0};
        vt[5] = '{1'b1, 8'h00, 8'h00, 8'h93, 8'h10, 8'h20, 4'h3, 16'h1020, 1, 3,  0};
        vt[6] = '{1'b0, 8'hAB, 8'hCD, 8'h03, 8'hAB, 8'hCD, 4'h3, 16'hABCD, 1, 20, 0};
        vt[7] = '{1'b0, 8'hFF, 8'hFF, 8'h02, 8'hFF, 8'hFF, 4'h2, 16'hFE01, 1, 1,  0};
        vt[8] = '{1'b0, 8'h0F, 8'h35, 8'h04, 8'h0F, 8'h35, 4'h4, 16'h003A, 3, 3,  0};

        // Reset state, observed while reset is held.
        #3 RST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 9; i++) run_frame(vt[i], $sformatf("vec%0d", i));

        // ALU never answers: timeout pulse, nothing transmitted.
        alu_never = 1'b1; alu_lat = 1; busy_len = 3; accept_delay = 0;
        en0 = en_count; err0 = err_count; v0 = vld_count;
        send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        wait_idle(50, "tmo");
        repeat (3) @(negedge CLK);
        check("tmo_err_pulses", 32'(err_count - err0), 32'd1);
        check("tmo_err_delay",  32'(err_cyc - en_cyc), 32'd9);
        check("tmo_busy_at_err", 32'(err_busy), 32'd0);
        check("tmo_alu_en_cnt", 32'(en_count - en0), 32'd1);
        check("tmo_no_tx_vld",  32'(vld_count - v0), 32'd0);
        check("tmo_cmd_err_low", 32'(CMD_ERR), 32'd0);
        check("tmo_A", 32'(A), 32'h01);
        check("tmo_B", 32'(B), 32'h02);
        alu_never = 1'b0;

        // TX_BUSY already high when the low byte is offered: single-cycle accept.
        force_busy = 1'b1;
        @(negedge CLK);
        acc0 = acc_count;
        exp_q.push_back(8'h0C); exp_q.push_back(8'h00);
        send_byte(8'hCC); send_byte(8'h03); send_byte(8'h04); send_byte(8'h02);
        n = 0;
        while (acc_count == acc0 && n < 50) begin @(negedge CLK); n++; end
        check("fb_first_accept", 32'(acc_count - acc0), 32'd1);
        check("fb_vld_cycles", 32'(last_run), 32'd1);
        force_busy = 1'b0;
        wait_idle(100, "fb");
        check("fb_tx_bytes", 32'(acc_count - acc0), 32'd2);
        check("fb_sb_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back: new 0xCC offered in the first IDLE cycle.
        alu_lat = 1; busy_len = 2; accept_delay = 0;
        acc0 = acc_count;
        exp_q.push_back(8'h05); exp_q.push_back(8'h00);
        send_byte(8'hCC); send_byte(8'h02); send_byte(8'h03); send_byte(8'h00);
        n = 0;
        while (CTRL_BUSY !== 1'b0 && n < 100) begin @(negedge CLK); n++; end
        check("b2b_first_idle", 32'(CTRL_BUSY), 32'd0);
        exp_q.push_back(8'h04); exp_q.push_back(8'h00);
        send_byte(8'hCC);
        check("b2b_accept", 32'(CTRL_BUSY), 32'd1);
        send_byte(8'h01); send_byte(8'h04); send_byte(8'h02);
        wait_idle(100, "b2b");
        check("b2b_A", 32'(A), 32'h01);
        check("b2b_B", 32'(B), 32'h04);
        check("b2b_tx_bytes", 32'(acc_count - acc0), 32'd4);
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // Bytes arriving in ALU_RUN, WAIT_VLD and SEND_LO are dropped.
        alu_lat = 4; busy_len = 3; accept_delay = 3;
        acc0 = acc_count;
        exp_q.push_back(8'h34); exp_q.push_back(8'h00);
        send_byte(8'hCC); send_byte(8'h21); send_byte(8'h13); send_byte(8'h00);
        send_byte(8'hCC); send_byte(8'hDD); send_byte(8'h05); send_byte(8'h66);
        n = 0;
        while (TX_D_VLD !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
        check("drop_send_lo_reached", 32'(TX_D_VLD), 32'd1);
        send_byte(8'hCC); send_byte(8'h99);
        check("drop_still_send_lo", 32'(TX_D_VLD), 32'd1);
        wait_idle(100, "drop");
        check("drop_A", 32'(A), 32'h21);
        check("drop_B", 32'(B), 32'h13);
        check("drop_ALU_FUN", 32'(ALU_FUN), 32'h0);
        check("drop_tx_bytes", 32'(acc_count - acc0), 32'd2);
        check("drop_sb_empty", 32'(exp_q.size()), 32'd0);
        accept_delay = 0; alu_lat = 1;

        // Junk in IDLE, reset mid-frame, junk after reset.
        send_byte(8'h7E);
        check("rst_ignore_7E", 32'(CTRL_BUSY), 32'd0);
        send_byte(8'hCC); send_byte(8'h11);
        check("rst_mid_busy", 32'(CTRL_BUSY), 32'd1);
        check("rst_mid_A", 32'(A), 32'h11);
        #2 RST = 1'b0;
        #1 check_all_zero("rst_async");
        exp_q.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        send_byte(8'h22);
        check_all_zero("rst_after_22");
        run_frame('{1'b0, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 4'h0, 16'h0002, 1, 3, 0}, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 8, operand/byte width.
REQ-002 SHALL have parameter OUT_WIDTH, 16, ALU result width.
REQ-003 SHALL have port CLK input 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port RST input 1, asynchronous active-low reset.
REQ-005 SHALL have port RX_P_DATA input DATA_WIDTH, received command/operand byte.
REQ-006 SHALL have port RX_D_VLD input 1, one-cycle strobe qualifying RX_P_DATA.
REQ-007 SHALL have port ALU_OUT input OUT_WIDTH, ALU result.
REQ-008 SHALL have port ALU_Valid input 1, ALU result valid.
REQ-009 SHALL have port TX_BUSY input 1, byte transmitter busy.
REQ-010 SHALL have port A output DATA_WIDTH, registered operand A.
REQ-011 SHALL have port B output DATA_WIDTH, registered operand B.
REQ-012 SHALL have port ALU_FUN output 4, registered ALU function code.
REQ-013 SHALL have port ALU_EN output 1, ALU enable.
REQ-014 SHALL have port TX_P_DATA output DATA_WIDTH, byte to transmit.
REQ-015 SHALL have port TX_D_VLD output 1, TX_P_DATA valid.
REQ-016 SHALL have port CTRL_BUSY output 1, high in every state except IDLE.
REQ-017 SHALL have port CMD_ERR output 1, one-cycle pulse on ALU timeout.

Function
REQ-018 SHALL implement FSM states IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_VLD, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI.
REQ-019 SHALL, in IDLE, on RX_D_VLD with byte 0xCC go to GET_A; with 0xDD go to GET_FUN (keep stored A/B); ignore any other byte.
REQ-020 SHALL, in GET_A/GET_B, on RX_D_VLD load A/B from RX_P_DATA and advance to GET_B/GET_FUN respectively.
REQ-021 SHALL, in GET_FUN, on RX_D_VLD load ALU_FUN from RX_P_DATA[3:0] (upper bits discarded), go to ALU_RUN.
REQ-022 SHALL hold in GET_* states indefinitely while RX_D_VLD low; no frame timeout.
REQ-023 SHALL drive ALU_EN high for exactly one cycle (the ALU_RUN cycle), then enter WAIT_VLD.
REQ-024 SHALL, in WAIT_VLD, on ALU_Valid capture ALU_OUT into a result register and go to SEND_LO.
REQ-025 SHALL count WAIT_VLD cycles; if ALU_Valid absent for 8 consecutive cycles, pulse CMD_ERR one cycle, go to IDLE, send nothing.
REQ-026 SHALL, in SEND_LO, drive TX_P_DATA=result[7:0], TX_D_VLD=1 until TX_BUSY sampled high, then go to WAIT_LO with TX_D_VLD=0.
REQ-027 SHALL, in WAIT_LO, wait for TX_BUSY low, then go to SEND_HI.
REQ-028 SHALL handle SEND_HI/WAIT_HI as SEND_LO/WAIT_LO with result[15:8], returning to IDLE.
REQ-029 SHALL, if TX_BUSY already high on SEND_LO/SEND_HI entry, keep TX_D_VLD high and accept on the first high sample (single-cycle accept).
REQ-030 SHALL ignore RX_D_VLD in ALU_RUN through WAIT_HI; bytes dropped, no queueing.
REQ-031 SHALL hold A, B, ALU_FUN stable outside their load cycles.
REQ-032 SHALL support back-to-back frames: 0xCC accepted in the cycle IDLE is re-entered.

Reset
REQ-033 SHALL, on RST low, asynchronously force IDLE and A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR, CTRL_BUSY, result register, timeout counter to 0.
REQ-034 SHALL, on reset mid-frame or mid-transmit, abandon the operation; first post-reset byte is decoded as a command in IDLE.

Verification
REQ-035 SHALL cover: RX 0xCC,0x05,0x03,0x00; ALU_OUT=0x0008 with ALU_Valid one cycle after ALU_EN -> ALU_EN one pulse, A=5, B=3, ALU_FUN=0, TX bytes 0x08 then 0x00.
REQ-036 SHALL cover: after REQ-035, RX 0xDD,0x02; ALU_OUT=0x000F -> A=5, B=3 unchanged, ALU_FUN=2, TX bytes 0x0F, 0x00.
REQ-037 SHALL cover: full frame, ALU_Valid never asserted -> CMD_ERR single pulse 8 cycles into WAIT_VLD, no TX_D_VLD, CTRL_BUSY low next cycle.
REQ-038 SHALL cover: TX_BUSY held high 20 cycles after first accept, result 0xABCD -> TX_D_VLD low throughout busy; 0xCD then 0xAB sent, never overlapping.
REQ-039 SHALL cover: RX 0x7E in IDLE, then RX 0xCC,0x11, RST low, RST high, RX 0x22 -> 0x7E and 0x22 ignored, all outputs 0, state IDLE.
REQ-040 SHALL cover: RX bytes during WAIT_VLD and SEND_LO -> dropped; A/B/ALU_FUN unchanged, transmitted result correct.
